// File: rtl/vend_pkg.sv
// Shared constants and FSM state type for the vending payout block.
package vend_pkg;

    localparam logic [7:0] DENOM_100 = 8'd100;
    localparam logic [7:0] DENOM_50  = 8'd50;
    localparam logic [7:0] DENOM_20  = 8'd20;
    localparam logic [7:0] DENOM_10  = 8'd10;
    localparam logic [7:0] DENOM_5   = 8'd5;

    localparam logic [1:0] BEV_NONE  = 2'd0;
    localparam logic [1:0] BEV_WATER = 2'd1;
    localparam logic [1:0] BEV_SODA  = 2'd2;

    typedef enum logic [2:0] {
        IDLE,
        DROP,
        PAYOUT,
        GAP,
        DONE,
        ERR
    } state_e;

endpackage

// File: rtl/vend_payout_if.sv
// Request/payout handshake bundle for vend_payout.
// VEND_PAYOUT_COIN_CNT_EN adds the coins_total counter output.
interface vend_payout_if;

    logic               req_valid;
    logic               req_ready;
    logic signed [31:0] change_in;
    logic signed [31:0] beverage_in;
    logic [1:0]         bev_drop;
    logic               coin_valid;
    logic [7:0]         coin_value;
    logic               done;
    logic               err;
`ifdef VEND_PAYOUT_COIN_CNT_EN
    logic [15:0]        coins_total;
`endif

    modport slave (
        input  req_valid, change_in, beverage_in,
        output req_ready, bev_drop, coin_valid, coin_value, done, err
`ifdef VEND_PAYOUT_COIN_CNT_EN
        , output coins_total
`endif
    );

    modport master (
        output req_valid, change_in, beverage_in,
        input  req_ready, bev_drop, coin_valid, coin_value, done, err
`ifdef VEND_PAYOUT_COIN_CNT_EN
        , input coins_total
`endif
    );

endinterface

// File: rtl/vend_coin_select.sv
// Combinational picker: largest denomination that fits in the remaining value.
module vend_coin_select
    import vend_pkg::*;
#(
    parameter int unsigned W = 10
) (
    input  logic [W-1:0] remaining,
    output logic [7:0]   denom
);

    always_comb begin
        denom = '0;
        if (remaining >= W'(DENOM_100)) begin
            denom = DENOM_100;
        end else if (remaining >= W'(DENOM_50)) begin
            denom = DENOM_50;
        end else if (remaining >= W'(DENOM_20)) begin
            denom = DENOM_20;
        end else if (remaining >= W'(DENOM_10)) begin
            denom = DENOM_10;
        end else if (remaining >= W'(DENOM_5)) begin
            denom = DENOM_5;
        end
    end

endmodule

// File: rtl/vend_payout.sv
// Vending payout controller: drops a beverage, then ejects change coin by coin.
// VEND_PAYOUT_COIN_CNT_EN enables the saturating coins_total counter.
module vend_payout
    import vend_pkg::*;
#(
    parameter int unsigned COIN_GAP   = 2,
    parameter int unsigned MAX_CHANGE = 500
) (
    input logic          clk,
    input logic          rst,
    vend_payout_if.slave bus
);

    localparam int unsigned REM_W    = ($clog2(MAX_CHANGE + 1) > 10) ? $clog2(MAX_CHANGE + 1) : 10;
    localparam int unsigned GAP_LAST = (COIN_GAP > 0) ? COIN_GAP - 1 : 0;

    state_e             state_q, state_d;
    logic [REM_W-1:0]   rem_q, rem_d;
    logic [1:0]         bev_q, bev_d;
    logic [31:0]        gap_q, gap_d;
    logic               armed_q;
    logic [7:0]         denom;
    logic               req_ok;
    logic               hs;
    logic               coin_vld;

    vend_coin_select #(.W(REM_W)) u_coin_select (
        .remaining (rem_q),
        .denom     (denom)
    );

    always_comb begin
        req_ok = 1'b1;
        if (bus.change_in < 32'sd0) req_ok = 1'b0;
        if (bus.change_in > $signed(32'(MAX_CHANGE))) req_ok = 1'b0;
        if ((bus.change_in % 32'sd5) != 32'sd0) req_ok = 1'b0;
        if ((bus.beverage_in < 32'sd0) || (bus.beverage_in > 32'sd2)) req_ok = 1'b0;
    end

    assign hs = bus.req_valid && bus.req_ready;

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        bev_d   = bev_q;
        gap_d   = gap_q;
        unique case (state_q)
            IDLE: begin
                if (hs) begin
                    if (req_ok) begin
                        rem_d   = bus.change_in[REM_W-1:0];
                        bev_d   = bus.beverage_in[1:0];
                        state_d = DROP;
                    end else begin
                        rem_d   = '0;
                        bev_d   = BEV_NONE;
                        state_d = ERR;
                    end
                end
            end
            DROP: state_d = PAYOUT;
            PAYOUT: begin
                if (rem_q == '0) begin
                    state_d = DONE;
                end else begin
                    rem_d   = rem_q - REM_W'(denom);
                    gap_d   = '0;
                    state_d = (COIN_GAP == 0) ? PAYOUT : GAP;
                end
            end
            GAP: begin
                if (gap_q == 32'(GAP_LAST)) begin
                    state_d = PAYOUT;
                end else begin
                    gap_d = gap_q + 32'd1;
                end
            end
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // armed_q holds ready low until the first edge after reset release
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            rem_q   <= '0;
            bev_q   <= BEV_NONE;
            gap_q   <= '0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            bev_q   <= bev_d;
            gap_q   <= gap_d;
            armed_q <= 1'b1;
        end
    end

    always_comb begin
        coin_vld       = (state_q == PAYOUT) && (rem_q != '0);
        bus.req_ready  = (state_q == IDLE) && armed_q;
        bus.bev_drop   = (state_q == DROP) ? bev_q : BEV_NONE;
        bus.coin_valid = coin_vld;
        bus.coin_value = coin_vld ? denom : '0;
        bus.done       = (state_q == DONE);
        bus.err        = (state_q == ERR);
    end

`ifdef VEND_PAYOUT_COIN_CNT_EN
    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (coin_vld && (cnt_q != '1)) cnt_d = cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

    assign bus.coins_total = cnt_q;
`endif

endmodule

// File: tb/tb_vend_payout.sv
// Directed self-checking bench for vend_payout (COIN_GAP=2 and COIN_GAP=0 instances).
module tb_vend_payout;

    logic clk;
    logic rst_n;

    vend_payout_if ifa ();
    vend_payout_if ifb ();

    vend_payout #(.COIN_GAP(2), .MAX_CHANGE(500)) dut_a (.clk(clk), .rst(rst_n), .bus(ifa));
    vend_payout #(.COIN_GAP(0), .MAX_CHANGE(500)) dut_b (.clk(clk), .rst(rst_n), .bus(ifb));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    int n_coins, drop_cnt, drop_code, drop_cyc, done_cyc, err_cyc, ready_early, bad_val;
    int coin_val [8];
    int coin_cyc [8];

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int sel, input logic v, input int chg, input int bev);
        if (sel == 0) begin
            ifa.req_valid = v; ifa.change_in = chg; ifa.beverage_in = bev;
        end else begin
            ifb.req_valid = v; ifb.change_in = chg; ifb.beverage_in = bev;
        end
    endtask

    task automatic sample(input int sel, output logic rdy, output logic [1:0] bd, output logic cv,
                          output logic [7:0] cval, output logic dn, output logic er);
        if (sel == 0) begin
            rdy = ifa.req_ready; bd = ifa.bev_drop; cv = ifa.coin_valid;
            cval = ifa.coin_value; dn = ifa.done; er = ifa.err;
        end else begin
            rdy = ifb.req_ready; bd = ifb.bev_drop; cv = ifb.coin_valid;
            cval = ifb.coin_value; dn = ifb.done; er = ifb.err;
        end
    endtask

    // Cycle k of the trace is the cycle that ends on the k-th edge after the handshake.
    task automatic serve(input int sel, input int chg, input int bev, input bit hold, input int rst_at);
        logic rdy, cv, dn, er;
        logic [1:0] bd;
        logic [7:0] cval;
        n_coins = 0; drop_cnt = 0; drop_code = 0; drop_cyc = -1;
        done_cyc = -1; err_cyc = -1; ready_early = 0; bad_val = 0;
        sample(sel, rdy, bd, cv, cval, dn, er);
        for (int i = 0; i < 20 && rdy !== 1'b1; i++) begin
            step();
            sample(sel, rdy, bd, cv, cval, dn, er);
        end
        chk("ready_before_req", 32'(rdy), 1);
        drive(sel, 1'b1, chg, bev);
        step();
        if (!hold) drive(sel, 1'b0, 5, 0);
        for (int k = 1; k <= 60; k++) begin
            sample(sel, rdy, bd, cv, cval, dn, er);
            if (cv === 1'b1) begin
                if (n_coins < 8) begin
                    coin_val[n_coins] = int'(cval);
                    coin_cyc[n_coins] = k;
                end
                n_coins++;
            end else if (cval !== 8'd0) begin
                bad_val++;
            end
            if (bd !== 2'd0) begin
                drop_cnt++; drop_code = int'(bd); drop_cyc = k;
            end
            if (rdy === 1'b1) ready_early++;
            if (dn === 1'b1) done_cyc = k;
            if (er === 1'b1) err_cyc = k;
            if (dn === 1'b1 || er === 1'b1) break;
            if (rst_at > 0 && n_coins == rst_at) begin
                rst_n = 1'b0;
                #1;
                sample(sel, rdy, bd, cv, cval, dn, er);
                chk("rst_req_ready", 32'(rdy), 0);
                chk("rst_bev_drop", 32'(bd), 0);
                chk("rst_coin_valid", 32'(cv), 0);
                chk("rst_coin_value", 32'(cval), 0);
                chk("rst_done", 32'(dn), 0);
                chk("rst_err", 32'(er), 0);
                break;
            end
            step();
        end
        drive(sel, 1'b0, 0, 0);
        chk("coin_value_idle_zero", 32'(bad_val), 0);
    endtask

    task automatic check_ready_next(input int sel, input string tag);
        logic rdy, cv, dn, er;
        logic [1:0] bd;
        logic [7:0] cval;
        step();
        sample(sel, rdy, bd, cv, cval, dn, er);
        chk(tag, 32'(rdy), 1);
    endtask

    initial begin
        logic rdy, cv, dn, er;
        logic [1:0] bd;
        logic [7:0] cval;
        int stray;

        rst_n = 1'b0;
        drive(0, 1'b0, 0, 0);
        drive(1, 1'b0, 0, 0);
        step();
        step();
        for (int s = 0; s < 2; s++) begin
            sample(s, rdy, bd, cv, cval, dn, er);
            chk("reset_req_ready", 32'(rdy), 0);
            chk("reset_bev_drop", 32'(bd), 0);
            chk("reset_coin_valid", 32'(cv), 0);
            chk("reset_done", 32'(dn), 0);
            chk("reset_err", 32'(er), 0);
        end
`ifdef VEND_PAYOUT_COIN_CNT_EN
        chk("reset_coins_total", 32'(ifa.coins_total), 0);
`endif
        rst_n = 1'b1;
        sample(0, rdy, bd, cv, cval, dn, er);
        chk("ready_before_first_edge", 32'(rdy), 0);
        step();
        sample(0, rdy, bd, cv, cval, dn, er);
        chk("ready_first_edge", 32'(rdy), 1);

        // change=185 soda, gap 2
        serve(0, 185, 2, 1'b0, 0);
        chk("r185_n_coins", 32'(n_coins), 5);
        chk("r185_c0", 32'(coin_val[0]), 100);
        chk("r185_c1", 32'(coin_val[1]), 50);
        chk("r185_c2", 32'(coin_val[2]), 20);
        chk("r185_c3", 32'(coin_val[3]), 10);
        chk("r185_c4", 32'(coin_val[4]), 5);
        for (int i = 0; i < 5; i++) chk("r185_coin_cycle", 32'(coin_cyc[i]), 32'(2 + 3 * i));
        chk("r185_drop_cnt", 32'(drop_cnt), 1);
        chk("r185_drop_code", 32'(drop_code), 2);
        chk("r185_drop_cyc", 32'(drop_cyc), 1);
        chk("r185_done_cyc", 32'(done_cyc), 18);
        chk("r185_err", 32'(err_cyc), 32'(-1));
        chk("r185_no_early_ready", 32'(ready_early), 0);
        check_ready_next(0, "r185_ready_after_done");

        // change=15, gap 0, req_valid held high
        serve(1, 15, 0, 1'b1, 0);
        chk("g0_n_coins", 32'(n_coins), 2);
        chk("g0_c0", 32'(coin_val[0]), 10);
        chk("g0_c1", 32'(coin_val[1]), 5);
        chk("g0_c0_cyc", 32'(coin_cyc[0]), 2);
        chk("g0_c1_cyc", 32'(coin_cyc[1]), 3);
        chk("g0_done_cyc", 32'(done_cyc), 5);
        chk("g0_no_reaccept", 32'(ready_early), 0);
        chk("g0_no_drop", 32'(drop_cnt), 0);
        check_ready_next(1, "g0_ready_after_done");

`ifdef VEND_PAYOUT_COIN_CNT_EN
        chk("coins_total_a", 32'(ifa.coins_total), 5);
        chk("coins_total_b", 32'(ifb.coins_total), 2);
        chk("coins_total_sum", 32'(ifa.coins_total) + 32'(ifb.coins_total), 7);
`endif

        // change=0 water
        serve(0, 0, 1, 1'b0, 0);
        chk("z_drop_code", 32'(drop_code), 1);
        chk("z_drop_cnt", 32'(drop_cnt), 1);
        chk("z_n_coins", 32'(n_coins), 0);
        chk("z_done_cyc", 32'(done_cyc), 3);

        // invalid requests
        serve(0, 37, 1, 1'b0, 0);
        chk("e37_err_cyc", 32'(err_cyc), 1);
        chk("e37_no_drop", 32'(drop_cnt), 0);
        chk("e37_no_coins", 32'(n_coins), 0);
        chk("e37_no_done", 32'(done_cyc), 32'(-1));
        check_ready_next(0, "e37_ready_hs_plus2");

        serve(0, 100, 3, 1'b0, 0);
        chk("ebev3_err_cyc", 32'(err_cyc), 1);
        chk("ebev3_no_drop", 32'(drop_cnt), 0);
        chk("ebev3_no_coins", 32'(n_coins), 0);
        check_ready_next(0, "ebev3_ready_hs_plus2");

        serve(0, 505, 0, 1'b0, 0);
        chk("e505_err_cyc", 32'(err_cyc), 1);
        serve(0, -5, 0, 1'b0, 0);
        chk("eneg_err_cyc", 32'(err_cyc), 1);

        serve(0, 500, 0, 1'b0, 0);
        chk("m500_n_coins", 32'(n_coins), 5);
        chk("m500_done_cyc", 32'(done_cyc), 18);
        chk("m500_err", 32'(err_cyc), 32'(-1));

        // change=300 interrupted by reset after 2nd coin
        serve(0, 300, 0, 1'b0, 2);
        chk("r300_coins_before_rst", 32'(n_coins), 2);
        step();
        step();
        rst_n = 1'b1;
        sample(0, rdy, bd, cv, cval, dn, er);
        chk("r300_ready_low_at_release", 32'(rdy), 0);
        step();
        sample(0, rdy, bd, cv, cval, dn, er);
        chk("r300_ready_first_edge", 32'(rdy), 1);
        stray = 0;
        for (int i = 0; i < 10; i++) begin
            sample(0, rdy, bd, cv, cval, dn, er);
            if (cv !== 1'b0 || dn !== 1'b0) stray++;
            step();
        end
        chk("r300_no_resume", 32'(stray), 0);

        serve(0, 40, 0, 1'b0, 0);
        chk("r40_n_coins", 32'(n_coins), 2);
        chk("r40_c0", 32'(coin_val[0]), 20);
        chk("r40_c1", 32'(coin_val[1]), 20);
        chk("r40_c1_cyc", 32'(coin_cyc[1]), 5);
        chk("r40_done_cyc", 32'(done_cyc), 9);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
